// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the default-slave state type.
//   HTRANS_*      : master transfer type encodings
//   HRESP_*       : slave response encodings (AHB-Lite uses only OKAY and ERROR)
//   dflt_state_t  : built-in default slave states (idle, first and second error cycle)
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } dflt_state_t;

endpackage

// File: rtl/ahb_resp_mux_n_if.sv
// Bus bundle between the master/decoder/slaves and the response multiplexer.
//   HSEL, HTRANS                    : address-phase select and transfer type
//   HRDATA_S, HRESP_S, HREADYOUT_S  : packed per-slave responses (slave i at slot i)
//   HRDATA, HRESP, HREADY           : muxed response to the master (HREADY also to slaves)
//   SEL_ERR, ERR_CNT                : multi-hot select pulse and default-slave error count
// Modports: slave = multiplexer side, master = master/decoder/slave-array side.
interface ahb_resp_mux_n_if #(
  parameter int unsigned NO_OF_PERIPHERALS = 4,
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned CNT_WIDTH         = 8
);

  logic [NO_OF_PERIPHERALS-1:0]            HSEL;
  logic [1:0]                              HTRANS;
  logic [NO_OF_PERIPHERALS*DATA_WIDTH-1:0] HRDATA_S;
  logic [2*NO_OF_PERIPHERALS-1:0]          HRESP_S;
  logic [NO_OF_PERIPHERALS-1:0]            HREADYOUT_S;
  logic [DATA_WIDTH-1:0]                   HRDATA;
  logic [1:0]                              HRESP;
  logic                                    HREADY;
  logic                                    SEL_ERR;
  logic [CNT_WIDTH-1:0]                    ERR_CNT;

  modport slave (
    input  HSEL, HTRANS, HRDATA_S, HRESP_S, HREADYOUT_S,
    output HRDATA, HRESP, HREADY, SEL_ERR, ERR_CNT
  );

  modport master (
    output HSEL, HTRANS, HRDATA_S, HRESP_S, HREADYOUT_S,
    input  HRDATA, HRESP, HREADY, SEL_ERR, ERR_CNT
  );

endinterface

// File: rtl/ahb_default_slave.sv
// Built-in AHB-Lite default slave: two-cycle ERROR response sequencer.
//   HCLK, HRESETn : clock, synchronous active-low reset
//   err_req       : error captured this edge (valid transfer, HSEL zero or multi-hot)
//   multi_req     : the captured error was a multi-hot HSEL
//   state         : current state, drives the response mux in the top
//   sel_err       : one-cycle pulse during ERR1 of a multi-hot error
//   err_cnt       : saturating count of ERROR responses started
module ahb_default_slave
  import ahb_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 err_req,
  input  logic                 multi_req,
  output dflt_state_t          state,
  output logic                 sel_err,
  output logic [CNT_WIDTH-1:0] err_cnt
);

  dflt_state_t          state_q, state_d;
  logic                 sel_err_q;
  logic [CNT_WIDTH-1:0] err_cnt_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DS_IDLE: if (err_req) state_d = DS_ERR1;
      DS_ERR1: state_d = DS_ERR2;
      // ERR2 drives HREADY high, so a new error can be captured here with no gap
      DS_ERR2: state_d = err_req ? DS_ERR1 : DS_IDLE;
      default: state_d = DS_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q   <= DS_IDLE;
      sel_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_err_q <= err_req & multi_req;
      if (err_req && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  assign state   = state_q;
  assign sel_err = sel_err_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: rtl/ahb_resp_mux_n.sv
// AHB-Lite slave-to-master response multiplexer for N peripherals.
// Registers the address-phase one-hot HSEL into a data-phase select and steers
// HRDATA/HRESP/HREADY from the selected slave back to the master. Unmapped or
// multi-hot selections on valid transfers are answered by a built-in default slave.
//   HCLK, HRESETn : clock, synchronous active-low reset
//   bus           : ahb_resp_mux_n_if slave modport (selects, slave responses, muxed outputs)
module ahb_resp_mux_n
  import ahb_pkg::*;
#(
  parameter int unsigned NO_OF_PERIPHERALS = 4,
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned CNT_WIDTH         = 8
) (
  input logic             HCLK,
  input logic             HRESETn,
  ahb_resp_mux_n_if.slave bus
);

  logic [NO_OF_PERIPHERALS-1:0] data_sel_q, data_sel_d;
  logic                         valid_trans;
  logic                         sel_onehot;
  logic                         sel_zero;
  logic                         capture;
  logic                         err_req;
  logic                         multi_req;
  dflt_state_t                  dflt_state;
  logic [DATA_WIDTH-1:0]        hrdata;
  logic [1:0]                   hresp;
  logic                         hready;
  logic                         unused_htrans;

  // Only HTRANS[1] distinguishes NONSEQ/SEQ from IDLE/BUSY
  assign valid_trans   = bus.HTRANS[1];
  assign unused_htrans = bus.HTRANS[0];

  assign sel_onehot = $onehot(bus.HSEL);
  assign sel_zero   = (bus.HSEL == '0);
  // Capture happens on any edge where the master sees HREADY high
  assign capture    = hready;
  assign err_req    = capture & valid_trans & ~sel_onehot;
  assign multi_req  = ~sel_onehot & ~sel_zero;

  always_comb begin
    data_sel_d = data_sel_q;
    if (capture) begin
      data_sel_d = (valid_trans && sel_onehot) ? bus.HSEL : '0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      data_sel_q <= '0;
    end else begin
      data_sel_q <= data_sel_d;
    end
  end

  ahb_default_slave #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_default_slave (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .err_req   (err_req),
    .multi_req (multi_req),
    .state     (dflt_state),
    .sel_err   (bus.SEL_ERR),
    .err_cnt   (bus.ERR_CNT)
  );

  // data_sel is always zero while the default slave is active, so the two
  // sources never overlap; with no source selected the bus idles OKAY/ready.
  always_comb begin
    hrdata = '0;
    hresp  = HRESP_OKAY;
    hready = 1'b1;
    if (dflt_state != DS_IDLE) begin
      hresp  = HRESP_ERROR;
      hready = (dflt_state == DS_ERR2);
    end else begin
      for (int i = 0; i < int'(NO_OF_PERIPHERALS); i++) begin
        if (data_sel_q[i]) begin
          hrdata = bus.HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
          hresp  = bus.HRESP_S[2*i +: 2];
          hready = bus.HREADYOUT_S[i];
        end
      end
    end
  end

  assign bus.HRDATA = hrdata;
  assign bus.HRESP  = hresp;
  assign bus.HREADY = hready;

endmodule

// File: tb/tb_ahb_resp_mux_n.sv
// Self-checking bench for ahb_resp_mux_n. Two instances share stimulus: one with an
// 8-bit error counter and one with a 2-bit counter to exercise saturation.
module tb_ahb_resp_mux_n;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;

  logic HCLK = 1'b0;
  logic HRESETn;

  always #5 HCLK = ~HCLK;

  ahb_resp_mux_n_if #(.NO_OF_PERIPHERALS(N), .DATA_WIDTH(DW), .CNT_WIDTH(8)) bus ();
  ahb_resp_mux_n_if #(.NO_OF_PERIPHERALS(N), .DATA_WIDTH(DW), .CNT_WIDTH(2)) bus_sat ();

  assign bus_sat.HSEL        = bus.HSEL;
  assign bus_sat.HTRANS      = bus.HTRANS;
  assign bus_sat.HRDATA_S    = bus.HRDATA_S;
  assign bus_sat.HRESP_S     = bus.HRESP_S;
  assign bus_sat.HREADYOUT_S = bus.HREADYOUT_S;

  ahb_resp_mux_n #(.NO_OF_PERIPHERALS(N), .DATA_WIDTH(DW), .CNT_WIDTH(8)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  ahb_resp_mux_n #(.NO_OF_PERIPHERALS(N), .DATA_WIDTH(DW), .CNT_WIDTH(2)) dut_sat (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus_sat)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: a pending data phase is either a slave index, an error with
  // some cycles left, or nothing. Counts are plain integers clipped on compare.
  bit m_known  = 1'b0;
  int m_slave  = -1;  // slave owning the data phase, -1 if none
  int m_err    = 0;   // default-slave error cycles remaining (2, 1 or 0)
  bit m_selerr = 1'b0;
  int m_cnt    = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic rand_slaves();
    for (int i = 0; i < int'(N); i++) begin
      bus.HRDATA_S[i*DW +: DW] = $urandom;
      bus.HRESP_S[2*i +: 2]    = ($urandom_range(0, 7) == 0) ? 2'b01 : 2'b00;
      bus.HREADYOUT_S[i]       = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic set_bus(input logic rstn, input logic [N-1:0] hsel, input logic [1:0] htrans);
    HRESETn    = rstn;
    bus.HSEL   = hsel;
    bus.HTRANS = htrans;
  endtask

  // Checks outputs mid-cycle against the model, then advances the model across
  // the next rising edge using the inputs that edge sees.
  task automatic cycle();
    logic       exp_ready;
    logic [1:0] exp_resp;
    logic [31:0] exp_data;
    int pc, idx;
    @(negedge HCLK);
    if (m_err == 2) begin
      exp_ready = 1'b0; exp_resp = 2'b01; exp_data = '0;
    end else if (m_err == 1) begin
      exp_ready = 1'b1; exp_resp = 2'b01; exp_data = '0;
    end else if (m_slave >= 0) begin
      exp_ready = bus.HREADYOUT_S[m_slave];
      exp_resp  = bus.HRESP_S[2*m_slave +: 2];
      exp_data  = bus.HRDATA_S[m_slave*DW +: DW];
    end else begin
      exp_ready = 1'b1; exp_resp = 2'b00; exp_data = '0;
    end
    if (m_known) begin
      check_val("hready",      64'(bus.HREADY),      64'(exp_ready));
      check_val("hresp",       64'(bus.HRESP),       64'(exp_resp));
      check_val("hrdata",      64'(bus.HRDATA),      64'(exp_data));
      check_val("sel_err",     64'(bus.SEL_ERR),     64'(m_selerr));
      check_val("err_cnt",     64'(bus.ERR_CNT),     64'(sat(m_cnt, 255)));
      check_val("err_cnt_sat", 64'(bus_sat.ERR_CNT), 64'(sat(m_cnt, 3)));
    end
    pc = 0; idx = -1;
    for (int i = 0; i < int'(N); i++) begin
      if (bus.HSEL[i]) begin pc++; idx = i; end
    end
    if (!HRESETn) begin
      m_known = 1'b1; m_slave = -1; m_err = 0; m_selerr = 1'b0; m_cnt = 0;
    end else if (exp_ready) begin
      m_selerr = bus.HTRANS[1] && (pc > 1);
      m_slave  = (bus.HTRANS[1] && pc == 1) ? idx : -1;
      if (bus.HTRANS[1] && pc != 1) begin
        m_err = 2; m_cnt++;
      end else begin
        m_err = 0;
      end
    end else begin
      m_selerr = 1'b0;
      if (m_err == 2) m_err = 1;
    end
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    logic [N-1:0] hs;
    set_bus(1'b0, N'($urandom), 2'($urandom));
    rand_slaves();
    #1;

    // Reset with random inputs for two cycles
    for (int k = 0; k < 2; k++) begin
      set_bus(1'b0, N'($urandom), 2'($urandom));
      rand_slaves();
      cycle();
    end
    set_bus(1'b1, '0, 2'b00);
    rand_slaves();
    cycle();

    // Read from slave 2 with two wait states; HSEL changes during wait are ignored
    set_bus(1'b1, 4'b0100, 2'b10);
    rand_slaves();
    cycle();
    for (int k = 0; k < 2; k++) begin
      set_bus(1'b1, N'($urandom), 2'b10);
      rand_slaves();
      bus.HREADYOUT_S[2] = 1'b0;
      cycle();
    end
    set_bus(1'b1, '0, 2'b00);
    rand_slaves();
    bus.HREADYOUT_S[2]      = 1'b1;
    bus.HRESP_S[5:4]        = 2'b00;
    bus.HRDATA_S[2*DW +: DW] = 32'hCAFE_F00D;
    cycle();

    // Three back-to-back unmapped transfers
    for (int k = 0; k < 6; k++) begin
      set_bus(1'b1, '0, 2'b10);
      rand_slaves();
      cycle();
    end
    set_bus(1'b1, '0, 2'b00);
    rand_slaves();
    cycle();
    check_val("cnt_after_3_unmapped", 64'(bus.ERR_CNT), 64'd3);
    check_val("cnt_sat_after_3",      64'(bus_sat.ERR_CNT), 64'd3);

    // Multi-hot on SEQ errors; same HSEL on IDLE does not
    set_bus(1'b1, 4'b0011, 2'b11);
    rand_slaves();
    cycle();
    for (int k = 0; k < 2; k++) begin
      set_bus(1'b1, '0, 2'b00);
      rand_slaves();
      cycle();
    end
    for (int k = 0; k < 2; k++) begin
      set_bus(1'b1, 4'b0011, 2'b00);
      rand_slaves();
      cycle();
    end
    check_val("cnt_after_multi",    64'(bus.ERR_CNT), 64'd4);
    check_val("cnt_sat_saturated",  64'(bus_sat.ERR_CNT), 64'd3);

    // Reset asserted during ERR1
    set_bus(1'b1, '0, 2'b10);
    rand_slaves();
    cycle();
    set_bus(1'b0, '0, 2'b10);
    rand_slaves();
    cycle();
    set_bus(1'b1, '0, 2'b00);
    rand_slaves();
    cycle();
    check_val("cnt_after_reset", 64'(bus.ERR_CNT), 64'd0);

    // Random traffic
    for (int k = 0; k < 500; k++) begin
      case ($urandom_range(0, 9))
        0, 1:    hs = '0;
        2, 3:    hs = N'($urandom);
        default: hs = N'(1) << $urandom_range(0, N-1);
      endcase
      set_bus(($urandom_range(0, 63) != 0), hs, 2'($urandom));
      rand_slaves();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ahb_resp_mux_n.md
# ahb_resp_mux_n

Parametrised AHB-Lite slave-to-master response multiplexer for N peripherals. It sits between the decoder/slaves and the single master. It registers the address-phase one-hot HSEL vector into a data-phase select, steers HRDATA/HRESP/HREADY back to the master, and contains a built-in default slave. The default slave returns the two-cycle AHB ERROR response for unmapped or multi-hot selections and keeps a saturating count of such errors.

## Interface
Parameters:
- NO_OF_PERIPHERALS, 4, number of slave channels N (≥2)
- DATA_WIDTH, 32, read data width
- CNT_WIDTH, 8, width of error counter

Ports:
- HCLK  in  1  bus clock; everything is on its rising edge
- HRESETn  in  1  reset; one clock; reset is synchronous and active-low
- HSEL  in  N  one-hot slave selects from decoder (address phase)
- HTRANS  in  2  master transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11)
- HRDATA_S  in  N*DATA_WIDTH  slave read data; slave i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- HRESP_S  in  2*N  slave responses; slave i at [2i +: 2]; OKAY=00, ERROR=01
- HREADYOUT_S  in  N  slave ready outputs
- HRDATA  out  DATA_WIDTH  muxed read data to master
- HRESP  out  2  muxed response to master
- HREADY  out  1  muxed ready; also fanned back to all slaves as HREADY
- SEL_ERR  out  1  one-cycle pulse: multi-hot HSEL sampled on a valid transfer
- ERR_CNT  out  CNT_WIDTH  saturating count of default-slave ERROR responses

## Operation
- Valid transfer: HTRANS[1]==1 (NONSEQ or SEQ). IDLE and BUSY are never errored.
- Capture edge: a rising HCLK edge at which HREADY==1.
- On a capture edge with a valid transfer and exactly one HSEL bit set: data_sel <= HSEL.
- In every other capture case: data_sel <= 0.
- data_sel holds while HREADY==0.
- Valid transfer with HSEL==0 or multi-hot HSEL at a capture edge: the default-slave FSM goes to ERR1.
- Multi-hot HSEL additionally drives SEL_ERR=1 for the cycle after capture.
- Default-slave FSM states:
  - IDLE: no error pending.
  - ERR1: HREADY=0, HRESP=01.
  - ERR2: HREADY=1, HRESP=01.
  - Transitions: IDLE→ERR1 on error capture; ERR1→ERR2 always; ERR2→ERR1 on a new error capture, else IDLE.
  - ERR2 is a capture edge, so back-to-back errors and normal transfers proceed with no gap.
- ERR_CNT increments on entry to ERR1 and saturates at 2^CNT_WIDTH−1.
- Output mux, combinational from data_sel and FSM state:
  - FSM in ERR1/ERR2: HRDATA=0, HRESP/HREADY as listed above.
  - data_sel one-hot (bit i): HRDATA/HRESP/HREADY follow slave i.
  - data_sel==0 and FSM IDLE: HREADY=1, HRESP=00, HRDATA=0.
- A slave's own two-cycle ERROR passes through unchanged. It is not counted.

## Timing
- Reset values, asserted on the first edge with HRESETn=0:
  - data_sel=0, FSM=IDLE, ERR_CNT=0, SEL_ERR=0
  - resulting outputs: HREADY=1, HRESP=00, HRDATA=0
- Reset mid-transfer or mid-error aborts immediately to these values. No completion cycle follows.
- Data-phase select takes effect 1 cycle after the address phase.
- Slave→master mux path has zero latency (combinational). There is no registered output stage.
- Wait states: while the selected HREADYOUT_S=0, HREADY=0 and data_sel is frozen. A new HSEL/HTRANS is ignored until HREADY=1.
- Default-slave error spans exactly 2 cycles (ERR1, ERR2). SEL_ERR rises in ERR1 only.
- HSEL with a non-one-hot value on IDLE/BUSY: no error, no SEL_ERR, data_sel=0.

## Structure
- Shared package ahb_pkg:
  - HTRANS encodings (HTRANS_IDLE/BUSY/NONSEQ/SEQ)
  - HRESP_OKAY=2'b00, HRESP_ERROR=2'b01
  - typedef dflt_state_t {DS_IDLE, DS_ERR1, DS_ERR2}
- Sub-module ahb_default_slave holds the FSM, ERR_CNT and SEL_ERR. The top holds data_sel capture, the one-hot check and the output mux.
- Output mux is a parametrised loop over N. There are no hard-coded per-slave cases.

## Test plan
- Reset: hold HRESETn=0 for 2 cycles with random inputs → HREADY=1, HRESP=00, HRDATA=0, ERR_CNT=0.
- Read from slave 2, N=4: HSEL=0100, HTRANS=10, then slave 2 drives HRDATA_S=0xCAFE_F00D, HREADYOUT=0 for 2 cycles then 1 → HREADY low 2 cycles, then HRDATA=0xCAFEF00D, HRESP=00; HSEL changes during the wait are ignored.
- Unmapped: HSEL=0000, HTRANS=10 → HREADY=0/HRESP=01, then HREADY=1/HRESP=01, ERR_CNT=1; repeated back-to-back 3 times → ERR_CNT=3 with no IDLE gap.
- Multi-hot: HSEL=0011, HTRANS=11 → SEL_ERR pulses 1 cycle, two-cycle ERROR, ERR_CNT+1; same HSEL with HTRANS=00 → OKAY, no pulse.
- Saturation: CNT_WIDTH=2, 5 unmapped transfers → ERR_CNT=3.
- Reset asserted during ERR1 → next cycle HREADY=1, HRESP=00, FSM IDLE, ERR_CNT=0.
